// File: rtl/program_loader.sv
// Program loader: streams words into instruction/data memories, then runs the core.
// Optional LOADER_CHECKSUM_EN adds an XOR checksum of every accepted word.
module program_loader #(
  parameter int DATA_W  = 32,
  parameter int I_DEPTH = 64,
  parameter int D_DEPTH = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         begin_load,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_word,
  input  logic                         add_into,
  input  logic                         load_end,
  input  logic                         exec_done,
  output logic                         imem_we,
  output logic                         dmem_we,
  output logic [$clog2(I_DEPTH)-1:0]   imem_addr,
  output logic [$clog2(D_DEPTH)-1:0]   dmem_addr,
  output logic [DATA_W-1:0]            imem_wdata,
  output logic [DATA_W-1:0]            dmem_wdata,
  output logic                         start_signal,
  output logic [$clog2(I_DEPTH+1)-1:0] i_count,
  output logic [$clog2(D_DEPTH+1)-1:0] d_count,
`ifdef LOADER_CHECKSUM_EN
  output logic [DATA_W-1:0]            checksum,
`endif
  output logic                         overflow
);
  localparam int IAW = $clog2(I_DEPTH);
  localparam int DAW = $clog2(D_DEPTH);
  localparam int ICW = $clog2(I_DEPTH + 1);
  localparam int DCW = $clog2(D_DEPTH + 1);
  localparam logic [ICW-1:0] I_FULL = ICW'(I_DEPTH);
  localparam logic [DCW-1:0] D_FULL = DCW'(D_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_e;

  state_e state_q, state_d;

  logic              accept;
  logic              enter_load;
  logic              imem_we_q, imem_we_d;
  logic              dmem_we_q, dmem_we_d;
  logic [IAW-1:0]    imem_addr_q, imem_addr_d;
  logic [DAW-1:0]    dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0] imem_wdata_q, imem_wdata_d;
  logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
  logic [ICW-1:0]    i_count_q, i_count_d;
  logic [DCW-1:0]    d_count_q, d_count_d;
  logic              overflow_q, overflow_d;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (begin_load) state_d = LOAD;
      LOAD:    if (load_end)   state_d = RUN;
      RUN:     if (exec_done)  state_d = HALT;
      HALT:    if (begin_load) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready     = 1'b0;
    start_signal = 1'b0;
    unique case (state_q)
      LOAD: in_ready = add_into ? (d_count_q != D_FULL)
                                : (i_count_q != I_FULL);
      RUN:  start_signal = 1'b1;
      default: ;
    endcase
  end

  assign accept     = in_valid & in_ready;
  assign enter_load = begin_load & ((state_q == IDLE) | (state_q == HALT));

  always_comb begin
    imem_we_d    = 1'b0;
    dmem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    dmem_addr_d  = dmem_addr_q;
    imem_wdata_d = imem_wdata_q;
    dmem_wdata_d = dmem_wdata_q;
    i_count_d    = i_count_q;
    d_count_d    = d_count_q;
    overflow_d   = overflow_q;
`ifdef LOADER_CHECKSUM_EN
    checksum_d   = checksum_q;
`endif
    if (enter_load) begin
      i_count_d  = '0;
      d_count_d  = '0;
      overflow_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      checksum_d = '0;
`endif
    end
    if (accept) begin
      if (add_into) begin
        dmem_we_d    = 1'b1;
        dmem_addr_d  = d_count_q[DAW-1:0];
        dmem_wdata_d = in_word;
        d_count_d    = d_count_q + DCW'(1);
      end else begin
        imem_we_d    = 1'b1;
        imem_addr_d  = i_count_q[IAW-1:0];
        imem_wdata_d = in_word;
        i_count_d    = i_count_q + ICW'(1);
      end
`ifdef LOADER_CHECKSUM_EN
      checksum_d = checksum_q ^ in_word;
`endif
    end
    // Offer refused only because the selected memory is full
    if ((state_q == LOAD) && in_valid && !in_ready) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      imem_we_q    <= 1'b0;
      dmem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      dmem_addr_q  <= '0;
      imem_wdata_q <= '0;
      dmem_wdata_q <= '0;
      i_count_q    <= '0;
      d_count_q    <= '0;
      overflow_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      checksum_q   <= '0;
`endif
    end else begin
      imem_we_q    <= imem_we_d;
      dmem_we_q    <= dmem_we_d;
      imem_addr_q  <= imem_addr_d;
      dmem_addr_q  <= dmem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      dmem_wdata_q <= dmem_wdata_d;
      i_count_q    <= i_count_d;
      d_count_q    <= d_count_d;
      overflow_q   <= overflow_d;
`ifdef LOADER_CHECKSUM_EN
      checksum_q   <= checksum_d;
`endif
    end
  end

  assign imem_we    = imem_we_q;
  assign dmem_we    = dmem_we_q;
  assign imem_addr  = imem_addr_q;
  assign dmem_addr  = dmem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign dmem_wdata = dmem_wdata_q;
  assign i_count    = i_count_q;
  assign d_count    = d_count_q;
  assign overflow   = overflow_q;
`ifdef LOADER_CHECKSUM_EN
  assign checksum   = checksum_q;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: per-cycle reference model compare plus directed literals.
// Define LOADER_CHECKSUM_EN to also exercise the checksum output.
module tb_program_loader;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          begin_load = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_word = '0;
  logic          add_into = 1'b0;
  logic          load_end = 1'b0;
  logic          exec_done = 1'b0;
  logic          imem_we, dmem_we;
  logic [1:0]    imem_addr, dmem_addr;
  logic [DW-1:0] imem_wdata, dmem_wdata;
  logic          start_signal;
  logic [2:0]    i_count, d_count;
  logic          overflow;
`ifdef LOADER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  program_loader #(.DATA_W(DW), .I_DEPTH(4), .D_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .begin_load(begin_load),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .add_into(add_into), .load_end(load_end), .exec_done(exec_done),
    .imem_we(imem_we), .dmem_we(dmem_we),
    .imem_addr(imem_addr), .dmem_addr(dmem_addr),
    .imem_wdata(imem_wdata), .dmem_wdata(dmem_wdata),
    .start_signal(start_signal), .i_count(i_count), .d_count(d_count),
`ifdef LOADER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 loading, 2 running, 3 halted
  int          m_phase = 0;
  int          m_icnt = 0, m_dcnt = 0;
  bit          m_ovf = 0;
  bit          m_iwe = 0, m_dwe = 0;
  int          m_iaddr = 0, m_daddr = 0;
  logic [31:0] m_iwd = 0, m_dwd = 0;
  logic [31:0] m_cks = 0;
  bit          chk_en = 0;

  always @(posedge clk) begin
    bit rdy, acc;
    rdy = (m_phase == 1) && (add_into ? (m_dcnt < 4) : (m_icnt < 4));
    acc = in_valid && rdy;
    if (!reset) begin
      m_phase = 0; m_icnt = 0; m_dcnt = 0; m_ovf = 0;
      m_iwe = 0; m_dwe = 0; m_cks = 0;
    end else begin
      m_iwe = acc && !add_into;
      m_dwe = acc && add_into;
      if (acc) begin
        if (add_into) begin
          m_daddr = m_dcnt; m_dwd = in_word; m_dcnt++;
        end else begin
          m_iaddr = m_icnt; m_iwd = in_word; m_icnt++;
        end
        m_cks = m_cks ^ in_word;
      end
      if (m_phase == 1 && in_valid && !rdy) m_ovf = 1;
      if ((m_phase == 0 || m_phase == 3) && begin_load) begin
        m_phase = 1; m_icnt = 0; m_dcnt = 0; m_ovf = 0; m_cks = 0;
      end else if (m_phase == 1 && load_end) m_phase = 2;
      else if (m_phase == 2 && exec_done) m_phase = 3;
    end
    chk_en = 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'((m_phase == 1) &&
          (add_into ? (m_dcnt < 4) : (m_icnt < 4))));
      chk("start", 32'(start_signal), 32'(m_phase == 2));
      chk("imem_we", 32'(imem_we), 32'(m_iwe));
      chk("dmem_we", 32'(dmem_we), 32'(m_dwe));
      chk("i_count", 32'(i_count), 32'(m_icnt));
      chk("d_count", 32'(d_count), 32'(m_dcnt));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (m_iwe) begin
        chk("imem_addr", 32'(imem_addr), 32'(m_iaddr));
        chk("imem_wdata", imem_wdata, m_iwd);
      end
      if (m_dwe) begin
        chk("dmem_addr", 32'(dmem_addr), 32'(m_daddr));
        chk("dmem_wdata", dmem_wdata, m_dwd);
      end
`ifdef LOADER_CHECKSUM_EN
      chk("checksum", checksum, m_cks);
`endif
    end
  end

  task automatic step(input logic bl, input logic iv, input logic ai,
                      input logic le, input logic ed, input logic [31:0] w);
    begin_load = bl; in_valid = iv; add_into = ai;
    load_end = le; exec_done = ed; in_word = w;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    idle(); idle();
    chk("rst start", 32'(start_signal), 32'h0);
    chk("rst i_count", 32'(i_count), 32'h0);
    chk("rst overflow", 32'(overflow), 32'h0);
    reset = 1'b1;
    idle();

    // Reset mid-load drops the pending strobe
    step(1, 0, 0, 0, 0, 32'h0);
    step(0, 1, 0, 0, 0, 32'h5);
    chk("pre-rst we", 32'(imem_we), 32'h1);
    step(0, 1, 0, 0, 0, 32'h6);
    reset = 1'b0;
    step(0, 1, 0, 0, 0, 32'h7);
    chk("mid-rst we", 32'(imem_we), 32'h0);
    chk("mid-rst i_count", 32'(i_count), 32'h0);
    chk("mid-rst addr", 32'(imem_addr), 32'h0);
    chk("mid-rst wdata", imem_wdata, 32'h0);
    reset = 1'b1;
    idle();

    // Back-to-back instruction words
    step(1, 0, 0, 0, 0, 32'h0);
    step(0, 1, 0, 0, 0, 32'h11);
    chk("b2b addr0", 32'(imem_addr), 32'h0);
    step(0, 1, 0, 0, 0, 32'h22);
    chk("b2b addr1", 32'(imem_addr), 32'h1);
    chk("b2b we1", 32'(imem_we), 32'h1);
    step(0, 1, 0, 0, 0, 32'h33);
    chk("b2b addr2", 32'(imem_addr), 32'h2);
    chk("b2b wdata2", imem_wdata, 32'h33);
    idle();
    chk("b2b i_count", 32'(i_count), 32'h3);
    chk("b2b we off", 32'(imem_we), 32'h0);

    // Fill imem, overflow, then data memory still accepts
    step(0, 1, 0, 0, 0, 32'h44);
    chk("fill i_count", 32'(i_count), 32'h4);
    step(0, 1, 0, 0, 0, 32'h55);
    chk("full we", 32'(imem_we), 32'h0);
    chk("full overflow", 32'(overflow), 32'h1);
    step(0, 1, 1, 0, 0, 32'h1);
    chk("d0 we", 32'(dmem_we), 32'h1);
    chk("d0 addr", 32'(dmem_addr), 32'h0);
    chk("d0 d_count", 32'(d_count), 32'h1);
    chk("ovf sticky", 32'(overflow), 32'h1);
    step(1, 0, 0, 0, 0, 32'h0);
    chk("bl in load ignored", 32'(d_count), 32'h1);

    // load_end with a simultaneous accept
    step(0, 1, 1, 1, 0, 32'hAA);
    chk("le dmem_we", 32'(dmem_we), 32'h1);
    chk("le wdata", dmem_wdata, 32'hAA);
    chk("le addr", 32'(dmem_addr), 32'h1);
    chk("run start", 32'(start_signal), 32'h1);
    step(1, 1, 1, 1, 0, 32'hBB);
    chk("run no we", 32'(dmem_we), 32'h0);
    chk("run d_count", 32'(d_count), 32'h2);
    step(0, 0, 0, 0, 1, 32'h0);
    chk("halt start", 32'(start_signal), 32'h0);
    step(0, 0, 0, 1, 1, 32'h0);

    // Reload from halt, then fill dmem
    step(1, 0, 0, 0, 0, 32'h0);
    chk("reload i_count", 32'(i_count), 32'h0);
    chk("reload overflow", 32'(overflow), 32'h0);
    step(0, 1, 0, 0, 0, 32'h99);
    chk("reload addr", 32'(imem_addr), 32'h0);
    chk("reload wdata", imem_wdata, 32'h99);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 32'hD0 + 32'(i));
    chk("dfull d_count", 32'(d_count), 32'h4);
    chk("dfull overflow", 32'(overflow), 32'h1);
    step(0, 1, 0, 1, 0, 32'h77);
    chk("i after dfull", 32'(imem_addr), 32'h1);
    step(0, 0, 0, 0, 1, 32'h0);

`ifdef LOADER_CHECKSUM_EN
    step(1, 0, 0, 0, 0, 32'h0);
    chk("cks clear", checksum, 32'h0);
    step(0, 1, 0, 0, 0, 32'hF0);
    chk("cks f0", checksum, 32'hF0);
    step(0, 1, 1, 0, 0, 32'h0F);
    step(0, 1, 0, 0, 0, 32'hFF);
    chk("cks final", checksum, 32'h00);
`endif
    idle(); idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
